// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall, bubble flush and exception redirect.
// Optional perf counters (stall_cnt, bubble_cnt) enabled by STAGE_PERF_CNT_EN.
module pipe_stage_reg #(
  parameter int unsigned PAYLOAD_W = 64,
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 req,
  input  logic [31:0]          in_pc,
  input  logic [31:0]          in_instr,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_valid,
  input  logic [4:0]           in_exc,
  input  logic [4:0]           stage_exc,
  input  logic                 in_bd,
`ifdef STAGE_PERF_CNT_EN
  output logic [31:0]          stall_cnt,
  output logic [31:0]          bubble_cnt,
`endif
  output logic [31:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_valid,
  output logic [4:0]           out_exc,
  output logic                 out_bd
);

  localparam int unsigned EXC_W = 5;

  // Earliest exception wins; bubbles never carry an exception.
  logic [EXC_W-1:0] merged_exc_c;
  always_comb begin
    merged_exc_c = '0;
    if (in_valid) begin
      merged_exc_c = (in_exc != '0) ? in_exc : stage_exc;
    end
  end

  // Stage contents: reset > req > flush > stall > load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_pc      <= PC_RESET;
      out_instr   <= '0;
      out_payload <= '0;
      out_valid   <= 1'b0;
      out_exc     <= '0;
      out_bd      <= 1'b0;
    end else if (req) begin
      out_pc      <= EXC_PC;
      out_instr   <= '0;
      out_payload <= '0;
      out_valid   <= 1'b0;
      out_exc     <= '0;
      out_bd      <= 1'b0;
    end else if (flush) begin
      // Bubble keeps PC/BD so a later exception can still form EPC.
      out_pc      <= in_pc;
      out_instr   <= '0;
      out_payload <= '0;
      out_valid   <= 1'b0;
      out_exc     <= '0;
      out_bd      <= in_bd;
    end else if (en) begin
      out_pc      <= in_pc;
      out_instr   <= in_instr;
      out_payload <= in_payload;
      out_valid   <= in_valid;
      out_exc     <= merged_exc_c;
      out_bd      <= in_bd;
    end
  end

`ifdef STAGE_PERF_CNT_EN
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic stall_hit_c;
  logic bubble_hit_c;
  assign stall_hit_c  = !en && !flush && !req && out_valid;
  assign bubble_hit_c = flush && !req;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_hit_c && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + 32'(1);
      end
      if (bubble_hit_c && (bubble_cnt != CNT_MAX)) begin
        bubble_cnt <= bubble_cnt + 32'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: expected stage contents queued per edge.
// Counter checks are compiled in only when STAGE_PERF_CNT_EN is defined.
module tb_pipe_stage_reg;

  localparam int unsigned PW = 64;
  localparam logic [31:0] PC_RST = 32'h0000_3000;
  localparam logic [31:0] PC_EXC = 32'h0000_4180;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [63:0] payload;
    logic        valid;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] scnt;
    logic [31:0] bcnt;
  } st_t;

  logic          clk = 1'b0;
  logic          reset, en, flush, req, in_valid, in_bd;
  logic [31:0]   in_pc, in_instr;
  logic [PW-1:0] in_payload;
  logic [4:0]    in_exc, stage_exc;
  logic [31:0]   out_pc, out_instr;
  logic [PW-1:0] out_payload;
  logic          out_valid, out_bd;
  logic [4:0]    out_exc;
`ifdef STAGE_PERF_CNT_EN
  logic [31:0]   stall_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;
  st_t m;
  st_t sb[$];

  pipe_stage_reg #(.PAYLOAD_W(PW), .PC_RESET(PC_RST), .EXC_PC(PC_EXC)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .req(req),
    .in_pc(in_pc), .in_instr(in_instr), .in_payload(in_payload),
    .in_valid(in_valid), .in_exc(in_exc), .stage_exc(stage_exc), .in_bd(in_bd),
`ifdef STAGE_PERF_CNT_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .out_pc(out_pc), .out_instr(out_instr), .out_payload(out_payload),
    .out_valid(out_valid), .out_exc(out_exc), .out_bd(out_bd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic st_t reset_state();
    st_t r;
    r.pc = PC_RST; r.instr = '0; r.payload = '0; r.valid = 1'b0;
    r.exc = '0; r.bd = 1'b0; r.scnt = '0; r.bcnt = '0;
    return r;
  endfunction

  task automatic compare_outputs(input string tag, input st_t e);
    check({tag, ".pc"}, 64'(out_pc), 64'(e.pc));
    check({tag, ".instr"}, 64'(out_instr), 64'(e.instr));
    check({tag, ".payload"}, 64'(out_payload), e.payload);
    check({tag, ".valid"}, 64'(out_valid), 64'(e.valid));
    check({tag, ".exc"}, 64'(out_exc), 64'(e.exc));
    check({tag, ".bd"}, 64'(out_bd), 64'(e.bd));
`ifdef STAGE_PERF_CNT_EN
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(e.scnt));
    check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(e.bcnt));
`endif
  endtask

  // Predict next contents from current inputs, queue it, then clock and compare.
  task automatic cycle(input string tag);
    st_t n;
    st_t e;
    n = m;
    if (req) begin
      n.pc = PC_EXC; n.instr = '0; n.payload = '0; n.valid = 1'b0; n.exc = '0; n.bd = 1'b0;
    end else if (flush) begin
      n.pc = in_pc; n.instr = '0; n.payload = '0; n.valid = 1'b0; n.exc = '0; n.bd = in_bd;
    end else if (en) begin
      n.pc = in_pc; n.instr = in_instr; n.payload = in_payload; n.valid = in_valid; n.bd = in_bd;
      n.exc = !in_valid ? 5'd0 : (in_exc != 5'd0) ? in_exc : stage_exc;
    end
    if (!req && !flush && !en && m.valid && m.scnt != 32'hFFFF_FFFF) n.scnt = m.scnt + 32'd1;
    if (flush && !req && m.bcnt != 32'hFFFF_FFFF) n.bcnt = m.bcnt + 32'd1;
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      compare_outputs(tag, e);
    end
  endtask

  task automatic drive(input logic e_, input logic f_, input logic r_, input logic [31:0] pc,
                       input logic [31:0] ins, input logic v, input logic [4:0] ie,
                       input logic [4:0] se, input logic bd);
    en = e_; flush = f_; req = r_; in_pc = pc; in_instr = ins; in_valid = v;
    in_exc = ie; stage_exc = se; in_bd = bd; in_payload = {pc, ins} ^ 64'hA5A5_0000_5A5A_FFFF;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h1111, 32'h2222, 1'b1, 5'd3, 5'd7, 1'b1);
    m = reset_state();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs("reset", m);

    // First load right after reset release.
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h3004, 32'h2408_0001, 1'b1, 5'd0, 5'd0, 1'b0);
    cycle("load0");
    check("load0.pc_lit", 64'(out_pc), 64'h3004);
    check("load0.instr_lit", 64'(out_instr), 64'h2408_0001);

    // Three stalls with changing inputs.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h5000 + 32'(i * 4), 32'hDEAD_0000 + 32'(i), 1'b1,
            5'(i + 1), 5'd9, 1'b1);
      cycle("stall");
    end
    check("stall.pc_lit", 64'(out_pc), 64'h3004);
`ifdef STAGE_PERF_CNT_EN
    check("stall.cnt_lit", 64'(stall_cnt), 64'd3);
`endif

    // Flush while stalled keeps PC/BD.
    drive(1'b0, 1'b1, 1'b0, 32'h3010, 32'h1234_5678, 1'b1, 5'd2, 5'd3, 1'b1);
    cycle("flush");
    check("flush.pc_lit", 64'(out_pc), 64'h3010);
    check("flush.bd_lit", 64'(out_bd), 64'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h3014, 32'h1, 1'b1, 5'd0, 5'd0, 1'b0);
    cycle("flush2");

    // Exception merge.
    drive(1'b1, 1'b0, 1'b0, 32'h3020, 32'hA, 1'b1, 5'd0, 5'd12, 1'b0);
    cycle("exc_stage");
    check("exc_stage.lit", 64'(out_exc), 64'd12);
    drive(1'b1, 1'b0, 1'b0, 32'h3024, 32'hB, 1'b1, 5'd4, 5'd12, 1'b0);
    cycle("exc_early");
    check("exc_early.lit", 64'(out_exc), 64'd4);
    drive(1'b1, 1'b0, 1'b0, 32'h3028, 32'hC, 1'b0, 5'd4, 5'd12, 1'b0);
    cycle("exc_invalid");
    check("exc_invalid.lit", 64'(out_exc), 64'd0);

    // Req beats flush.
    drive(1'b1, 1'b1, 1'b1, 32'h3030, 32'hD, 1'b1, 5'd1, 5'd1, 1'b1);
    cycle("req");
    check("req.pc_lit", 64'(out_pc), 64'h4180);

    // Async reset mid-stall, between edges.
    drive(1'b1, 1'b0, 1'b0, 32'h3040, 32'hE, 1'b1, 5'd0, 5'd0, 1'b0);
    cycle("pre_rst");
    drive(1'b0, 1'b0, 1'b0, 32'h3044, 32'hF, 1'b1, 5'd0, 5'd0, 1'b0);
    #2 reset = 1'b1;
    #1;
    m = reset_state();
    compare_outputs("async_rst", m);
    check("async_rst.pc_lit", 64'(out_pc), 64'h3000);
    #2 reset = 1'b0;

    // Random mix.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
            $urandom(), $urandom(), 1'($urandom()),
            ($urandom_range(0, 2) == 0) ? 5'($urandom()) : 5'd0, 5'($urandom()), 1'($urandom()));
      cycle("rand");
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
